// File: rtl/bp_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module      : bp_perf_monitor
// Description : Multi-channel branch-prediction statistics collector.
//               Counts resolved branches, mispredictions and run cycles for
//               NUM_CH predictor channels with run/stop/clear control,
//               saturating counters, per-window mispredict snapshots and a
//               registered readout port.
//               Optional macro BP_MON_STREAK_EN adds per-channel mispredict
//               streak tracking and the rd_ext_i readout remap input.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_perf_monitor #(
    parameter int NUM_CH      = 2,
    parameter int CNT_WIDTH   = 32,
    parameter int WINDOW_LOG2 = 8,
    localparam int c_CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic                 clear_i,
    input  logic [NUM_CH-1:0]    br_instr_i,
    input  logic [NUM_CH-1:0]    br_miss_i,
    input  logic [c_CH_W-1:0]    rd_ch_i,
    input  logic [1:0]           rd_sel_i,
`ifdef BP_MON_STREAK_EN
    input  logic                 rd_ext_i,
`endif
    output logic [CNT_WIDTH-1:0] rd_data_o,
    output logic [NUM_CH-1:0]    win_vld_o,
    output logic [NUM_CH-1:0]    ovf_o,
    output logic                 busy_o
);

    localparam logic [1:0]             c_ST_IDLE  = 2'd0;
    localparam logic [1:0]             c_ST_RUN   = 2'd1;
    localparam logic [1:0]             c_ST_DONE  = 2'd2;
    localparam logic [CNT_WIDTH-1:0]   c_CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0]   c_CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [WINDOW_LOG2-1:0] c_IDX_LAST = '1;
    localparam logic [WINDOW_LOG2-1:0] c_IDX_ONE  = WINDOW_LOG2'(1);
    localparam logic [c_CH_W:0]        c_NUM_CH   = (c_CH_W + 1)'(NUM_CH);

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic                 w_run;
    logic [CNT_WIDTH-1:0] r_cycles;
    logic [CNT_WIDTH-1:0] w_cycles_next;
    logic                 w_cyc_sat;
    logic [CNT_WIDTH-1:0] w_rd_val;
    logic [CNT_WIDTH-1:0] w_rd_br   [NUM_CH];
    logic [CNT_WIDTH-1:0] w_rd_miss [NUM_CH];
    logic [CNT_WIDTH-1:0] w_rd_snap [NUM_CH];
`ifdef BP_MON_STREAK_EN
    logic [CNT_WIDTH-1:0] w_rd_str  [NUM_CH];
`endif

    // Next-state decode: clear beats stop, stop beats start
    always_comb begin
        w_state_next = r_state;
        if (clear_i) begin
            w_state_next = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_RUN:             if (stop_i)  w_state_next = c_ST_DONE;
                c_ST_IDLE, c_ST_DONE: if (start_i) w_state_next = c_ST_RUN;
                default:              w_state_next = c_ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= c_ST_IDLE;
        else       r_state <= w_state_next;
    end

    assign w_run  = (r_state == c_ST_RUN);
    assign busy_o = w_run;

    assign w_cycles_next = (w_run && (r_cycles != c_CNT_MAX)) ? r_cycles + c_CNT_ONE : r_cycles;
    assign w_cyc_sat     = (w_cycles_next == c_CNT_MAX);

    // Shared run-cycle counter, saturating
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) r_cycles <= '0;
        else                  r_cycles <= w_cycles_next;
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CNT_WIDTH-1:0]   r_br;
        logic [CNT_WIDTH-1:0]   r_miss;
        logic [CNT_WIDTH-1:0]   r_acc;
        logic [CNT_WIDTH-1:0]   r_snap;
        logic [WINDOW_LOG2-1:0] r_idx;
        logic                   r_vld;
        logic                   r_ovf;
        logic                   w_br_ev;
        logic                   w_miss_ev;
        logic                   w_wrap;
        logic                   w_str_sat;
        logic [CNT_WIDTH-1:0]   w_br_next;
        logic [CNT_WIDTH-1:0]   w_miss_next;
        logic [CNT_WIDTH-1:0]   w_acc_next;

        // A miss only counts when it accompanies a resolved branch
        assign w_br_ev     = w_run & br_instr_i[gi];
        assign w_miss_ev   = w_br_ev & br_miss_i[gi];
        assign w_wrap      = w_br_ev && (r_idx == c_IDX_LAST);
        assign w_br_next   = (w_br_ev && (r_br != c_CNT_MAX)) ? r_br + c_CNT_ONE : r_br;
        assign w_miss_next = (w_miss_ev && (r_miss != c_CNT_MAX)) ? r_miss + c_CNT_ONE : r_miss;
        // Accumulator value including this branch's miss, used for the snapshot
        assign w_acc_next  = (w_miss_ev && (r_acc != c_CNT_MAX)) ? r_acc + c_CNT_ONE : r_acc;

        // Event counters, window tracking and sticky overflow
        always_ff @(posedge clk_i) begin
            if (rst_i || clear_i) begin
                r_br   <= '0;
                r_miss <= '0;
                r_acc  <= '0;
                r_snap <= '0;
                r_idx  <= '0;
                r_vld  <= 1'b0;
                r_ovf  <= 1'b0;
            end else begin
                r_br   <= w_br_next;
                r_miss <= w_miss_next;
                if (w_br_ev) r_idx <= r_idx + c_IDX_ONE;
                if (w_wrap) begin
                    r_snap <= w_acc_next;
                    r_acc  <= '0;
                end else begin
                    r_acc  <= w_acc_next;
                end
                r_vld  <= w_wrap;
                r_ovf  <= r_ovf | (w_br_next == c_CNT_MAX) | (w_miss_next == c_CNT_MAX)
                        | w_cyc_sat | w_str_sat;
            end
        end

`ifdef BP_MON_STREAK_EN
        logic [CNT_WIDTH-1:0] r_cur;
        logic [CNT_WIDTH-1:0] r_max;
        logic [CNT_WIDTH-1:0] w_cur_next;

        // A correct branch breaks the streak; a miss extends it (saturating)
        assign w_cur_next = !w_br_ev         ? r_cur :
                            !br_miss_i[gi]   ? '0 :
                            (r_cur != c_CNT_MAX) ? r_cur + c_CNT_ONE : r_cur;
        assign w_str_sat  = (w_cur_next == c_CNT_MAX);

        // Current and maximum mispredict streak
        always_ff @(posedge clk_i) begin
            if (rst_i || clear_i) begin
                r_cur <= '0;
                r_max <= '0;
            end else begin
                r_cur <= w_cur_next;
                if (w_cur_next > r_max) r_max <= w_cur_next;
            end
        end

        assign w_rd_str[gi] = r_max;
`else
        assign w_str_sat = 1'b0;
`endif

        assign w_rd_br[gi]   = r_br;
        assign w_rd_miss[gi] = r_miss;
        assign w_rd_snap[gi] = r_snap;
        assign win_vld_o[gi] = r_vld;
        assign ovf_o[gi]     = r_ovf;
    end

    // Readout mux; channels beyond NUM_CH read as zero
    always_comb begin
        w_rd_val = '0;
        if ({1'b0, rd_ch_i} < c_NUM_CH) begin
            case (rd_sel_i)
`ifdef BP_MON_STREAK_EN
                2'd0:    w_rd_val = rd_ext_i ? w_rd_str[rd_ch_i] : w_rd_br[rd_ch_i];
`else
                2'd0:    w_rd_val = w_rd_br[rd_ch_i];
`endif
                2'd1:    w_rd_val = w_rd_miss[rd_ch_i];
                2'd2:    w_rd_val = w_rd_snap[rd_ch_i];
                default: w_rd_val = r_cycles;
            endcase
        end
    end

    // Registered readout; keeps sampling through clear
    always_ff @(posedge clk_i) begin
        if (rst_i) rd_data_o <= '0;
        else       rd_data_o <= w_rd_val;
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_bp_perf_monitor
// Description : Scoreboard bench for bp_perf_monitor (NUM_CH=3, CNT_WIDTH=4,
//               WINDOW_LOG2=2). Stimulus queues expectations; a monitor
//               process pops and compares them against the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_perf_monitor;

    localparam int NCH = 3;
    localparam int CW  = 4;
    localparam int WL  = 2;

    typedef struct {
        string      name;
        int         kind;   // 0 busy, 1 ovf, 2 win_vld (status queue only)
        logic [3:0] exp;
    } chk_t;

    logic          clk = 1'b0;
    logic          rst, start, stop, clear;
    logic [2:0]    bi, bm;
    logic [1:0]    rd_ch, rd_sel;
`ifdef BP_MON_STREAK_EN
    logic          rd_ext = 1'b0;
`endif
    logic [CW-1:0] rd_data;
    logic [2:0]    win_vld, ovf;
    logic          busy;

    chk_t rd_q[$];
    chk_t st_q[$];
    logic rd_req = 1'b0, rd_req_d = 1'b0, st_req = 1'b0, fin = 1'b0;
    int   total = 0, bad = 0;

    always #5 clk = ~clk;

    bp_perf_monitor #(.NUM_CH(NCH), .CNT_WIDTH(CW), .WINDOW_LOG2(WL)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .stop_i     (stop),
        .clear_i    (clear),
        .br_instr_i (bi),
        .br_miss_i  (bm),
        .rd_ch_i    (rd_ch),
        .rd_sel_i   (rd_sel),
`ifdef BP_MON_STREAK_EN
        .rd_ext_i   (rd_ext),
`endif
        .rd_data_o  (rd_data),
        .win_vld_o  (win_vld),
        .ovf_o      (ovf),
        .busy_o     (busy)
    );

    // Readout has one cycle of latency
    always @(posedge clk) rd_req_d <= rd_req;

    // Monitor: pops expectations when the DUT presents the matching output
    always @(negedge clk) begin
        chk_t       it;
        logic [3:0] act;
        if (rd_req_d) begin
            total++;
            if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: got=%0d want=<queued entry>", rd_data);
            end else begin
                it = rd_q.pop_front();
                if (rd_data !== it.exp) begin
                    bad++;
                    $display("FAIL %s: got=%0d want=%0d", it.name, rd_data, it.exp);
                end
            end
        end
        if (st_req) begin
            while (st_q.size() > 0) begin
                it = st_q.pop_front();
                case (it.kind)
                    0:       act = {3'b000, busy};
                    1:       act = {1'b0, ovf};
                    default: act = {1'b0, win_vld};
                endcase
                total++;
                if (act !== it.exp) begin
                    bad++;
                    $display("FAIL %s: got=%b want=%b", it.name, act, it.exp);
                end
            end
        end
        if (fin) begin
            total++;
            if (rd_q.size() + st_q.size() != 0) begin
                bad++;
                $display("FAIL leftover_checks: got=%0d want=0", rd_q.size() + st_q.size());
            end
        end
    end

    task automatic step(input logic [2:0] i_bi, input logic [2:0] i_bm,
                        input logic i_st, input logic i_sp, input logic i_cl);
        bi = i_bi; bm = i_bm; start = i_st; stop = i_sp; clear = i_cl;
        @(posedge clk);
        #1;
        bi = '0; bm = '0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        rd_req = 1'b0; st_req = 1'b0;
    endtask

    // Queue a status expectation checked during the next step
    task automatic expect_st(input string nm, input int k, input logic [3:0] e);
        chk_t c;
        c.name = nm; c.kind = k; c.exp = e;
        st_q.push_back(c);
        st_req = 1'b1;
    endtask

    // Issue a readout in an otherwise idle cycle and queue its expected value
    task automatic rd(input string nm, input logic [1:0] ch, input logic [1:0] sel,
                      input logic [3:0] e);
        chk_t c;
        c.name = nm; c.kind = 0; c.exp = e;
        rd_ch = ch; rd_sel = sel;
        rd_q.push_back(c);
        rd_req = 1'b1;
        step(3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
        bi = '0; bm = '0; rd_ch = '0; rd_sel = '0;
        step(0, 0, 0, 0, 0);
        expect_st("rst_busy", 0, 4'd0);
        expect_st("rst_ovf", 1, 4'd0);
        expect_st("rst_win", 2, 4'd0);
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
        rd("rst_rd", 2'd0, 2'd0, 4'd0);

        // 10 RUN cycles on ch0, misses on 3 and 7; ch1 misses without branches
        step(0, 0, 1, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            if (k == 1) expect_st("run_busy", 0, 4'd1);
            expect_st("a_win_vld", 2, (k == 5 || k == 9) ? 4'd1 : 4'd0);
            step(3'b001, {1'b0, k <= 5, (k == 3 || k == 7)}, 0, k == 10, 0);
        end
        expect_st("a_done_busy", 0, 4'd0);
        expect_st("a_ovf", 1, 4'd0);
        expect_st("a_win_idle", 2, 4'd0);
        step(0, 0, 0, 0, 0);
        rd("a_br_ch0",   2'd0, 2'd0, 4'd10);
        rd("a_miss_ch0", 2'd0, 2'd1, 4'd2);
        rd("a_cyc_ch0",  2'd0, 2'd3, 4'd10);
        rd("a_win_ch0",  2'd0, 2'd2, 4'd1);
        rd("a_br_ch1",   2'd1, 2'd0, 4'd0);
        rd("a_miss_ch1", 2'd1, 2'd1, 4'd0);
        rd("a_br_ch2",   2'd2, 2'd0, 4'd0);
        rd("a_oor_ch",   2'd3, 2'd3, 4'd0);

        // Clear, then stop/resume cycle accounting
        step(0, 0, 0, 0, 1);
        expect_st("b_clr_busy", 0, 4'd0);
        step(0, 0, 0, 0, 0);
        rd("b_clr_br",  2'd0, 2'd0, 4'd0);
        rd("b_clr_win", 2'd0, 2'd2, 4'd0);
        rd("b_clr_cyc", 2'd0, 2'd3, 4'd0);
        step(0, 0, 1, 0, 0);
        for (int k = 1; k <= 6; k++) step(0, 0, 0, k == 6, 0);
        for (int k = 1; k <= 5; k++) begin
            if (k == 3) expect_st("b_idle_busy", 0, 4'd0);
            step(0, 0, 0, 0, 0);
        end
        step(0, 0, 1, 0, 0);
        for (int k = 1; k <= 4; k++) step(0, 0, 0, k == 4, 0);
        rd("b_cyc10", 2'd0, 2'd3, 4'd10);
        step(0, 0, 1, 0, 0);
        expect_st("b_ss_run_busy", 0, 4'd1);
        step(0, 0, 1, 1, 0);
        expect_st("b_ss_done_busy", 0, 4'd0);
        step(0, 0, 0, 0, 0);
        rd("b_cyc11", 2'd0, 2'd3, 4'd11);
        step(0, 0, 1, 1, 0);
        expect_st("b_ss_resume_busy", 0, 4'd1);
        step(0, 0, 0, 1, 0);
        rd("b_cyc12", 2'd0, 2'd3, 4'd12);

        // Window of 4: misses on 2nd and 4th, 5th branch starts next window
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            expect_st("c_win_vld", 2, (k == 5) ? 4'd1 : 4'd0);
            step((k <= 5) ? 3'b001 : 3'b000, (k == 2 || k == 4) ? 3'b001 : 3'b000, 0, k == 6, 0);
        end
        expect_st("c_win_after", 2, 4'd0);
        step(0, 0, 0, 0, 0);
        rd("c_snap", 2'd0, 2'd2, 4'd2);
        rd("c_br",   2'd0, 2'd0, 4'd5);
        rd("c_miss", 2'd0, 2'd1, 4'd2);
        rd("c_cyc",  2'd0, 2'd3, 4'd6);

        // Saturation with 4-bit counters
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            if (k == 10) expect_st("d_ovf_pre", 1, 4'd0);
            if (k == 16) expect_st("d_ovf_hit", 1, 4'd7);
            step(3'b001, 3'b000, 0, k == 20, 0);
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        expect_st("d_ovf_sticky", 1, 4'd7);
        step(0, 0, 0, 0, 0);
        rd("d_br_sat",  2'd0, 2'd0, 4'd15);
        rd("d_cyc_sat", 2'd0, 2'd3, 4'd15);
        rd("d_miss",    2'd0, 2'd1, 4'd0);
        step(0, 0, 0, 0, 1);
        expect_st("d_clr_ovf", 1, 4'd0);
        expect_st("d_clr_busy", 0, 4'd0);
        step(0, 0, 0, 0, 0);
        rd("d_clr_br",  2'd0, 2'd0, 4'd0);
        rd("d_clr_cyc", 2'd0, 2'd3, 4'd0);

`ifdef BP_MON_STREAK_EN
        // Streak pattern M,M,M,hit,M,M
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        for (int k = 1; k <= 6; k++) step(3'b001, (k != 4) ? 3'b001 : 3'b000, 0, k == 6, 0);
        rd_ext = 1'b1;
        rd("e_max_streak", 2'd0, 2'd0, 4'd3);
        rd_ext = 1'b0;
        rd("e_br", 2'd0, 2'd0, 4'd6);
`endif

        fin = 1'b1;
        step(0, 0, 0, 0, 0);
        fin = 1'b0;
        step(0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bp_perf_monitor.md
Name: bp_perf_monitor

Overview:
- Multi-channel branch-prediction statistics collector for the pipelined core benches.
- Counts resolved branches, mispredictions and run cycles for NUM_CH predictor instances side by side.
- Adds run/stop/clear control, saturating counters, per-window mispredict snapshots and a registered readout port.
- Replaces ad-hoc per-variant probe wiring with one reusable monitor instantiated next to the predictor pipelines.

Parameters:
- NUM_CH, 2, number of monitored predictor channels (1..8).
- CNT_WIDTH, 32, width of every event counter.
- WINDOW_LOG2, 8, window length = 2**WINDOW_LOG2 resolved branches per channel.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  begin or resume counting.
- stop_i  in  1  freeze counting.
- clear_i  in  1  zero all counters and return to IDLE.
- br_instr_i  in  NUM_CH  per-channel branch/jump resolved this cycle.
- br_miss_i  in  NUM_CH  per-channel misprediction flush this cycle.
- rd_ch_i  in  $clog2(NUM_CH) (min 1)  readout channel select.
- rd_sel_i  in  2  readout select: 0 branches, 1 misses, 2 last-window misses, 3 run cycles.
- rd_data_o  out  CNT_WIDTH  registered readout.
- win_vld_o  out  NUM_CH  one-cycle pulse: new window snapshot available.
- ovf_o  out  NUM_CH  sticky: any counter of that channel saturated.
- busy_o  out  1  high in RUN.

Behaviour:
- Reset (rst_i high at clock edge):
  - state IDLE; all counters, window accumulators and snapshots 0.
  - rd_data_o, win_vld_o, ovf_o, busy_o all 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start_i.
  - RUN -> DONE on stop_i.
  - DONE -> RUN on start_i (resume; values kept).
  - Any state -> IDLE on clear_i, zeroing everything reset zeroes except rd_data_o, which keeps updating.
  - Priority: rst_i > clear_i > stop_i > start_i. Consequences:
    - start_i+stop_i together in RUN: go to DONE.
    - start_i+stop_i together in IDLE or DONE: go to RUN (stop is meaningless there).
- busy_o = (state == RUN), registered, so it rises the cycle after the accepting start_i.
- Counting happens only in the cycle the state register is RUN. The cycle in which start_i is sampled is not counted; the cycle in which stop_i is sampled is counted.
- Per channel c, in RUN:
  - branches += br_instr_i[c].
  - misses += (br_miss_i[c] & br_instr_i[c]). A miss without br_instr is ignored.
- cycles: shared counter, +1 every RUN cycle.
- Saturation: every counter holds at all-ones and never wraps. Saturating any counter of channel c sets ovf_o[c] until reset or clear. The shared cycle counter sets ovf_o on all channels.
- Window, per channel:
  - WINDOW_LOG2-bit branch index and a CNT_WIDTH window-miss accumulator.
  - On the branch that wraps the index to 0, the snapshot is loaded with accumulator + this branch's miss, the accumulator restarts at 0, and win_vld_o[c] pulses for one cycle in the following cycle.
  - stop_i preserves a partial window; clear_i discards it.
- Readout: rd_data_o <= selected value at every edge (1-cycle latency), in any state. It returns pre-update values for events in the same cycle.
- Out-of-range rd_ch_i returns 0.

Optional Feature:
- Macro BP_MON_STREAK_EN.
- When defined:
  - Each channel tracks its current consecutive-mispredict streak and its maximum streak, both CNT_WIDTH, saturating.
  - A correctly predicted branch resets the current streak to 0.
  - A new input rd_ext_i (1 bit) remaps rd_sel_i 0 to the max streak when rd_ext_i=1.
  - Streaks clear on clear_i and reset.
- When undefined:
  - No streak logic and no rd_ext_i port.
  - Readout map exactly as above.

Test Plan:
- Reset, then start_i, then 10 RUN cycles with br_instr_i[0]=1 every cycle and br_miss_i[0]=1 on cycles 3 and 7 -> rd_sel 0/1/3 on ch0 read 10/2/10; ch1 reads 0; busy_o=1.
- br_miss_i[1]=1 with br_instr_i[1]=0 for 5 cycles -> ch1 misses stay 0.
- WINDOW_LOG2=2, 4 branches with misses on the 2nd and 4th -> win_vld_o[0] pulses once, one cycle after the 4th branch; rd_sel 2 reads 2. The 5th branch produces no pulse.
- stop_i after 6 cycles, idle 5 cycles, start_i, 4 more cycles -> cycles=10. Next, start_i+stop_i in the same RUN cycle -> DONE, busy_o falls next cycle.
- CNT_WIDTH=4, 20 branches on ch0 -> branches=15 (holds), ovf_o[0]=1 and stays 1. clear_i -> all counts 0, ovf_o=0, state IDLE.
- BP_MON_STREAK_EN: miss pattern M,M,M,hit,M,M -> max streak=3, current=2. rd_ext_i=1 with rd_sel 0 reads 3.
